// File: rtl/sram_ctrl_if.sv
// Request/response bus between a load/store requester and the SRAM controller.
// One valid/ready handshake per direction; the requester drives req_* and rsp_ready.
interface sram_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_ctrl.sv
// Single-port word memory with valid/ready request/response, byte-enable writes,
// configurable wait states, out-of-range error and a zero-fill sweep after reset.
module sram_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = 7,
    parameter int WAIT_STATES = 0
) (
    input  logic         clk,
    input  logic         rst,
    sram_ctrl_if.slave   bus,
    output logic         init_done
);
    localparam int                BE_W      = DATA_W / 8;
    localparam bit                NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]        WAIT_LAST = 4'(WAIT_STATES - 1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [3:0]          wcnt;
    logic                a_we_q;
    logic [ADDR_W-1:0]   a_addr_q;
    logic [DATA_W-1:0]   a_wdata_q;
    logic [BE_W-1:0]     a_be_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                acc_fire;
    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [BE_W-1:0]     acc_be;
    logic                acc_in_range;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_idx;
    logic [DATA_W-1:0]   mem_data;
    logic [BE_W-1:0]     mem_be;

    // Without wait states the access happens on the accept edge, so operands come straight from the bus.
    always_comb begin
        acc_fire  = 1'b0;
        acc_we    = a_we_q;
        acc_addr  = a_addr_q;
        acc_wdata = a_wdata_q;
        acc_be    = a_be_q;
        if (state == IDLE) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
            acc_fire  = NO_WAIT && bus.req_valid && req_ready_q;
        end else if (state == WAIT) begin
            acc_fire  = (wcnt == WAIT_LAST);
        end
        acc_in_range = ({1'b0, acc_addr} < DEPTH_X);
    end

    always_comb begin
        mem_we   = (state == INIT) || (acc_fire && acc_we && acc_in_range);
        mem_idx  = (state == INIT) ? cnt : acc_addr;
        mem_data = (state == INIT) ? '0  : acc_wdata;
        mem_be   = (state == INIT) ? '1  : acc_be;
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            cnt         <= '0;
            wcnt        <= '0;
            a_we_q      <= 1'b0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            a_be_q      <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            init_done   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == CNT_LAST) begin
                        state       <= IDLE;
                        init_done   <= 1'b1;
                        req_ready_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        a_we_q      <= bus.req_we;
                        a_addr_q    <= bus.req_addr;
                        a_wdata_q   <= bus.req_wdata;
                        a_be_q      <= bus.req_be;
                        req_ready_q <= 1'b0;
                        wcnt        <= '0;
                        state       <= NO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (wcnt == WAIT_LAST) state <= RESP;
                    else                   wcnt  <= wcnt + 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
            if (acc_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= !acc_in_range;
                rsp_rdata_q <= (acc_in_range && !acc_we) ? mem[acc_addr] : '0;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: two instances (DEPTH=128/no wait, DEPTH=100/3 wait states)
// driven from directed vectors, corner sequences and random traffic against a word-array model.
module tb_sram_ctrl;
    logic        clk;
    logic        rst       [2];
    logic        init_done [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [6:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int          n_chk  = 0;
    int          n_fail = 0;
    int          depth_of [2] = '{128, 100};
    int          ws_of    [2] = '{0, 3};
    logic [31:0] model [2][128];

    sram_ctrl_if #(.DATA_W(32), .ADDR_W(7)) if0 ();
    sram_ctrl_if #(.DATA_W(32), .ADDR_W(7)) if1 ();

    assign if0.req_valid = req_valid[0];
    assign if0.req_we    = req_we[0];
    assign if0.req_addr  = req_addr[0];
    assign if0.req_wdata = req_wdata[0];
    assign if0.req_be    = req_be[0];
    assign if0.rsp_ready = rsp_ready[0];
    assign req_ready[0]  = if0.req_ready;
    assign rsp_valid[0]  = if0.rsp_valid;
    assign rsp_rdata[0]  = if0.rsp_rdata;
    assign rsp_err[0]    = if0.rsp_err;

    assign if1.req_valid = req_valid[1];
    assign if1.req_we    = req_we[1];
    assign if1.req_addr  = req_addr[1];
    assign if1.req_wdata = req_wdata[1];
    assign if1.req_be    = req_be[1];
    assign if1.rsp_ready = rsp_ready[1];
    assign req_ready[1]  = if1.req_ready;
    assign rsp_valid[1]  = if1.rsp_valid;
    assign rsp_rdata[1]  = if1.rsp_rdata;
    assign rsp_err[1]    = if1.rsp_err;

    sram_ctrl #(.DATA_W(32), .DEPTH(128), .ADDR_W(7), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .bus(if0), .init_done(init_done[0])
    );
    sram_ctrl #(.DATA_W(32), .DEPTH(100), .ADDR_W(7), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst(rst[1]), .bus(if1), .init_done(init_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    typedef struct {
        int          d;
        logic        we;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input int d, input logic we, input logic [6:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] rd, input logic er);
        vec_t v;
        v = '{d, we, addr, wd, be, rd, er};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no event within cycle budget, required one (t=%0t)", name, $time);
    endtask

    // Word-level behaviour: out-of-range is an error, writes merge enabled bytes, reads return the word.
    task automatic model_access(input int d, input logic we, input logic [6:0] addr, input logic [31:0] wd,
                                input logic [3:0] be, output logic [31:0] rd, output logic er);
        logic [31:0] m;
        rd = '0;
        er = 1'b0;
        if (int'(addr) >= depth_of[d]) begin
            er = 1'b1;
        end else if (we) begin
            m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            model[d][addr] = (model[d][addr] & ~m) | (wd & m);
        end else begin
            rd = model[d][addr];
        end
    endtask

    task automatic do_reset(input int d);
        int k;
        @(negedge clk);
        rst[d] = 1'b1;
        #1;
        chk("reset_flags", {28'b0, req_ready[d], rsp_valid[d], rsp_err[d], init_done[d]}, 32'h0);
        chk("reset_rdata", rsp_rdata[d], 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst[d] = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!init_done[d] && k < depth_of[d] + 20);
        chk("init_cycles", k, depth_of[d]);
        chk("ready_after_init", req_ready[d], 1'b1);
        for (int i = 0; i < 128; i++) model[d][i] = '0;
    endtask

    task automatic xact(input int d, input logic we, input logic [6:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        req_be[d]    = be;
        n = 0;
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) timeout_fail("req_ready_wait");
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom);
        req_addr[d]  = 7'($urandom);
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            chk("ready_low_pending", req_ready[d], 1'b0);
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[d]) timeout_fail("rsp_valid_wait");
        rd = rsp_rdata[d];
        er = rsp_err[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_held", {29'b0, rsp_valid[d], req_ready[d], rsp_err[d]}, {29'b0, 1'b1, 1'b0, er});
            chk("rdata_held", rsp_rdata[d], rd);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("rsp_cleared", {29'b0, req_ready[d], rsp_valid[d], rsp_err[d]}, 32'b100);
        chk("rdata_cleared", rsp_rdata[d], 32'h0);
    endtask

    task automatic run_checked(input int d, input logic we, input logic [6:0] addr, input logic [31:0] wd,
                               input logic [3:0] be, input int hold, input string tag);
        logic [31:0] exp_rd, rd;
        logic        exp_er, er;
        int          lat;
        model_access(d, we, addr, wd, be, exp_rd, exp_er);
        xact(d, we, addr, wd, be, hold, rd, er, lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, er, exp_er);
        chk({tag, "_latency"}, lat, 1 + ws_of[d]);
    endtask

    task automatic throughput(input int d);
        int n, acc;
        @(negedge clk);
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b0;
        req_addr[d]  = 7'd0;
        req_be[d]    = 4'h0;
        rsp_ready[d] = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[d]) acc++;
            @(negedge clk);
        end
        req_valid[d] = 1'b0;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        rsp_ready[d] = 1'b0;
        chk("throughput_accepts", acc, 20 / (2 + ws_of[d]));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, n, d;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0;   req_be[i] = '0;   rsp_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        do_reset(0);
        do_reset(1);

        add(0, 0, 7'd5,   32'h0,        4'h0, 32'h0,        0);
        add(0, 1, 7'd3,   32'hDEADBEEF, 4'hF, 32'h0,        0);
        add(0, 0, 7'd3,   32'h0,        4'h0, 32'hDEADBEEF, 0);
        add(0, 1, 7'd3,   32'h11223344, 4'h5, 32'h0,        0);
        add(0, 0, 7'd3,   32'h0,        4'h0, 32'hDE22BE44, 0);
        add(0, 1, 7'd3,   32'hFFFFFFFF, 4'h0, 32'h0,        0);
        add(0, 0, 7'd3,   32'h0,        4'h0, 32'hDE22BE44, 0);
        add(0, 1, 7'd127, 32'hCAFEF00D, 4'hA, 32'h0,        0);
        add(0, 0, 7'd127, 32'h0,        4'h0, 32'hCA00F000, 0);
        add(1, 0, 7'd100, 32'h0,        4'h0, 32'h0,        1);
        add(1, 1, 7'd100, 32'h12345678, 4'hF, 32'h0,        1);
        add(1, 0, 7'd99,  32'h0,        4'h0, 32'h0,        0);
        add(1, 0, 7'd36,  32'h0,        4'h0, 32'h0,        0);
        add(1, 0, 7'd0,   32'h0,        4'h0, 32'h0,        0);
        add(1, 1, 7'd99,  32'h12345678, 4'hF, 32'h0,        0);
        add(1, 0, 7'd99,  32'h0,        4'h0, 32'h12345678, 0);
        add(1, 0, 7'd127, 32'h0,        4'h0, 32'h0,        1);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] m_rd;
            logic        m_er;
            model_access(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, m_rd, m_er);
            xact(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, rd, er, lat);
            chk("vec_rdata", rd, vecs[i].exp_rd);
            chk("vec_err", er, vecs[i].exp_err);
            chk("vec_latency", lat, 1 + ws_of[vecs[i].d]);
        end

        // Slow consumer with wait states: response must hold until taken.
        run_checked(1, 1'b1, 7'd42, 32'h0BADF00D, 4'hF, 0, "ws_write");
        run_checked(1, 1'b0, 7'd42, 32'h0,        4'h0, 5, "ws_slow_read");
        run_checked(0, 1'b0, 7'd3,  32'h0,        4'h0, 3, "slow_read");

        throughput(0);
        throughput(1);

        // Reset while a write sits in WAIT: no response, no commit, whole array re-zeroed.
        run_checked(1, 1'b1, 7'd8, 32'hA5A5A5A5, 4'hF, 0, "pre_reset_write");
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 7'd7;
        req_wdata[1] = 32'hA5A5A5A5; req_be[1] = 4'hF;
        n = 0;
        while (!req_ready[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("in_wait_no_rsp", rsp_valid[1], 1'b0);
        rst[1] = 1'b1;
        #1;
        chk("midop_reset_rsp_valid", rsp_valid[1], 1'b0);
        chk("midop_reset_init_done", init_done[1], 1'b0);
        do_reset(1);
        run_checked(1, 1'b0, 7'd7, 32'h0, 4'h0, 0, "post_reset_addr7");
        run_checked(1, 1'b0, 7'd8, 32'h0, 4'h0, 0, "post_reset_addr8");

        for (int i = 0; i < 200; i++) begin
            logic [6:0] a;
            d = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 15));
            run_checked(d, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 2)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
